// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector for a raster-order RGB pixel stream.
// Grey samples pass through two line buffers into a 3x3 window; results appear two cycles after the window's newest pixel.
module sobel_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cam_red_i,
    input  logic [DATA_W-1:0] cam_green_i,
    input  logic [DATA_W-1:0] cam_blue_i,
    input  logic              cam_done_i,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] thresh_i,
    output logic [DATA_W-1:0] sobel_red_o,
    output logic [DATA_W-1:0] sobel_green_o,
    output logic [DATA_W-1:0] sobel_blue_o,
    output logic              sobel_done_o,
    output logic              busy_o
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);
    localparam int GW = DATA_W + 3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);

    function automatic logic [DATA_W-1:0] to_grey(input logic [DATA_W-1:0] r,
                                                  input logic [DATA_W-1:0] g,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W+1:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[DATA_W+1:2];
    endfunction

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
        return signed'({3'b000, p});
    endfunction

    function automatic logic [DATA_W-1:0] sat_mag(input logic signed [GW-1:0] gx,
                                                  input logic signed [GW-1:0] gy);
        logic [GW-1:0] ax;
        logic [GW-1:0] ay;
        logic [GW:0]   sum;
        ax  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
        ay  = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
        sum = {1'b0, ax} + {1'b0, ay};
        if (|sum[GW:DATA_W]) return {DATA_W{1'b1}};
        return sum[DATA_W-1:0];
    endfunction

    logic [1:0]           state;
    logic [CW-1:0]        col;
    logic [CW-1:0]        ccol;
    logic [RW-1:0]        row;
    logic [RW-1:0]        crow;
    logic [FW-1:0]        flush_cnt;
    logic [1:0]           mode_q;
    logic [DATA_W-1:0]    thresh_q;
    logic [DATA_W-1:0]    lb_top [IMG_W];
    logic [DATA_W-1:0]    lb_mid [IMG_W];
    logic [DATA_W-1:0]    win_p0 [3][3];
    logic                 vld_p0;
    logic                 border_p0;
    logic [DATA_W-1:0]    res_p1;
    logic                 vld_p1;
    logic                 flushing;
    logic                 take;
    logic                 shift;
    logic                 emit;
    logic [DATA_W-1:0]    pix_in;
    logic [DATA_W-1:0]    top_in;
    logic [DATA_W-1:0]    mid_in;
    logic signed [GW-1:0] gx;
    logic signed [GW-1:0] gy;
    logic [DATA_W-1:0]    mag;
    logic [DATA_W-1:0]    res;

    // Flush cycles push zero pixels through so the last IMG_W+1 centres still get emitted.
    assign flushing = (state == S_FLUSH);
    assign take     = cam_done_i && !flushing;
    assign shift    = take || flushing;
    assign emit     = flushing || (take && state == S_RUN);
    assign pix_in   = flushing ? '0 : to_grey(cam_red_i, cam_green_i, cam_blue_i);
    assign top_in   = lb_top[col];
    assign mid_in   = lb_mid[col];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            flush_cnt <= '0;
            mode_q    <= '0;
            thresh_q  <= '0;
        end else begin
            if (shift) col <= (col == COL_LAST) ? '0 : col + 1'b1;
            if (take && col == COL_LAST) row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            case (state)
                S_IDLE: begin
                    if (take) begin
                        state    <= S_FILL;
                        mode_q   <= mode_i;
                        thresh_q <= thresh_i;
                    end
                end
                S_FILL: begin
                    if (take && row == RW'(1) && col == '0) state <= S_RUN;
                end
                S_RUN: begin
                    if (take && row == ROW_LAST && col == COL_LAST) begin
                        state     <= S_FLUSH;
                        flush_cnt <= '0;
                    end
                end
                default: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state <= S_IDLE;
                        col   <= '0;
                        row   <= '0;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (shift) begin
            lb_top[col] <= mid_in;
            lb_mid[col] <= pix_in;
        end
    end

    // Stage p0: window shift and centre-position bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ccol      <= '0;
            crow      <= '0;
            vld_p0    <= 1'b0;
            border_p0 <= 1'b0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win_p0[r][c] <= '0;
            end
        end else begin
            vld_p0 <= emit;
            if (shift) begin
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= top_in;
                win_p0[1][2] <= mid_in;
                win_p0[2][2] <= pix_in;
            end
            if (emit) begin
                border_p0 <= (ccol == '0) || (ccol == COL_LAST) || (crow == '0) || (crow == ROW_LAST);
                ccol      <= (ccol == COL_LAST) ? '0 : ccol + 1'b1;
                if (ccol == COL_LAST) crow <= (crow == ROW_LAST) ? '0 : crow + 1'b1;
            end
        end
    end

    always_comb begin
        gx = (ext(win_p0[0][2]) + (ext(win_p0[1][2]) <<< 1) + ext(win_p0[2][2]))
           - (ext(win_p0[0][0]) + (ext(win_p0[1][0]) <<< 1) + ext(win_p0[2][0]));
        gy = (ext(win_p0[2][0]) + (ext(win_p0[2][1]) <<< 1) + ext(win_p0[2][2]))
           - (ext(win_p0[0][0]) + (ext(win_p0[0][1]) <<< 1) + ext(win_p0[0][2]));
        mag = sat_mag(gx, gy);
        res = '0;
        case (mode_q)
            2'd1:    res = (mag >= thresh_q) ? '1 : '0;
            2'd2:    res = win_p0[1][1];
            default: res = mag;
        endcase
        if (border_p0 && mode_q != 2'd2) res = '0;
    end

    // Stage p1: registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            res_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) res_p1 <= res;
        end
    end

    assign sobel_red_o   = res_p1;
    assign sobel_green_o = res_p1;
    assign sobel_blue_o  = res_p1;
    assign sobel_done_o  = vld_p1;
    assign busy_o        = flushing;

endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream on 4x4 frames: directed flat/edge/grey frames, randomized frames with gaps,
// and resets mid-frame and mid-flush, all scored against a whole-image Sobel reference.
module tb_sobel_stream;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] cam_r, cam_g, cam_b;
    logic          cam_done;
    logic [1:0]    mode;
    logic [DW-1:0] thresh;
    logic [DW-1:0] so_r, so_g, so_b;
    logic          so_done;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pr[N], pg[N], pb[N];
    int acc_cyc[N];
    int expv[N];
    logic [23:0] out_q[$];
    int          outc_q[$];

    sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst),
        .cam_red_i(cam_r), .cam_green_i(cam_g), .cam_blue_i(cam_b),
        .cam_done_i(cam_done), .mode_i(mode), .thresh_i(thresh),
        .sobel_red_o(so_r), .sobel_green_o(so_g), .sobel_blue_o(so_b),
        .sobel_done_o(so_done), .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (so_done) begin
            out_q.push_back({so_r, so_g, so_b});
            outc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic int gr(input int r, input int c);
        int i;
        i = r * W + c;
        return (pr[i] + 2 * pg[i] + pb[i]) / 4;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void build_expect(input int md, input int th);
        int gx, gy, mag;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (md == 2) expv[r*W+c] = gr(r, c);
                else if (r == 0 || r == H-1 || c == 0 || c == W-1) expv[r*W+c] = 0;
                else begin
                    gx = (gr(r-1,c+1) + 2*gr(r,c+1) + gr(r+1,c+1)) - (gr(r-1,c-1) + 2*gr(r,c-1) + gr(r+1,c-1));
                    gy = (gr(r+1,c-1) + 2*gr(r+1,c) + gr(r+1,c+1)) - (gr(r-1,c-1) + 2*gr(r-1,c) + gr(r-1,c+1));
                    mag = iabs(gx) + iabs(gy);
                    if (mag > 255) mag = 255;
                    expv[r*W+c] = (md == 1) ? ((mag >= th) ? 255 : 0) : mag;
                end
            end
        end
    endfunction

    function automatic void fill_flat(input int r, input int g, input int b);
        for (int i = 0; i < N; i++) begin
            pr[i] = r; pg[i] = g; pb[i] = b;
        end
    endfunction

    function automatic void fill_edge();
        for (int i = 0; i < N; i++) begin
            pr[i] = ((i % W) >= 2) ? 255 : 0;
            pg[i] = pr[i]; pb[i] = pr[i];
        end
    endfunction

    function automatic void fill_rand(input int maxv);
        for (int i = 0; i < N; i++) begin
            pr[i] = $urandom_range(maxv); pg[i] = $urandom_range(maxv); pb[i] = $urandom_range(maxv);
        end
    endfunction

    task automatic drive_frame(input int md, input int th, input int gap_max, input int npix);
        int gaps;
        for (int i = 0; i < npix; i++) begin
            gaps = $urandom_range(gap_max);
            repeat (gaps) begin
                @(negedge clk);
                cam_done = 1'b0;
                cam_r = DW'($urandom); cam_g = DW'($urandom); cam_b = DW'($urandom);
                if (i > 0) begin mode = 2'($urandom); thresh = DW'($urandom); end
            end
            @(negedge clk);
            cam_done = 1'b1;
            cam_r = DW'(pr[i]); cam_g = DW'(pg[i]); cam_b = DW'(pb[i]);
            if (i == 0) begin mode = 2'(md); thresh = DW'(th); end
            else begin mode = 2'($urandom); thresh = DW'($urandom); end
            acc_cyc[i] = cyc;
        end
    endtask

    task automatic tail(input bit drop, output int busy_cnt, output int busy_at_drop);
        busy_cnt = 0;
        busy_at_drop = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (drop && i == 1) begin
                cam_done = 1'b1;
                cam_r = DW'($urandom); cam_g = DW'($urandom); cam_b = DW'($urandom);
                busy_at_drop = int'(busy);
            end else begin
                cam_done = 1'b0;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic check_frame(input string tag, input int md, input int th);
        int n_out, te;
        logic [7:0] e;
        build_expect(md, th);
        chk({tag, " count"}, out_q.size(), N);
        n_out = (out_q.size() < N) ? out_q.size() : N;
        for (int k = 0; k < n_out; k++) begin
            te = (k + W + 1 < N) ? acc_cyc[k+W+1] + 2 : acc_cyc[N-1] + (k + W + 1 - N) + 3;
            e  = 8'(expv[k]);
            chk($sformatf("%s px%0d val", tag, k), 32'(out_q[k]), {8'h00, e, e, e});
            chk($sformatf("%s px%0d cyc", tag, k), outc_q[k], te);
        end
        out_q.delete();
        outc_q.delete();
    endtask

    initial begin
        int bc, bd, md, th;
        cam_done = 1'b0; cam_r = '0; cam_g = '0; cam_b = '0; mode = '0; thresh = '0;
        repeat (3) @(negedge clk);
        chk("reset done", 32'(so_done), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset data", 32'({so_r, so_g, so_b}), 0);
        rst = 1'b1;
        @(negedge clk);

        fill_flat(100, 100, 100); drive_frame(0, 0, 0, N); tail(0, bc, bd); check_frame("flat_m0", 0, 0);
        fill_edge();              drive_frame(0, 0, 0, N); tail(0, bc, bd); check_frame("edge_m0", 0, 0);
        fill_edge();              drive_frame(1, 128, 3, N); tail(0, bc, bd); check_frame("edge_m1", 1, 128);
        fill_flat(100, 100, 100); drive_frame(1, 128, 2, N); tail(0, bc, bd); check_frame("flat_m1", 1, 128);

        fill_flat(40, 80, 120); drive_frame(2, 0, 0, N); tail(1, bc, bd);
        chk("busy length", bc, 5);
        chk("busy at drop", bd, 1);
        check_frame("grey_m2", 2, 0);

        for (int f = 0; f < 8; f++) begin
            fill_rand((f % 2 == 0) ? 31 : 255);
            md = $urandom_range(3);
            th = $urandom_range(255);
            drive_frame(md, th, $urandom_range(2), N);
            tail(0, bc, bd);
            check_frame($sformatf("rand%0d_m%0d", f, md), md, th);
        end

        fill_rand(255); drive_frame(0, 0, 0, 7);
        @(negedge clk);
        cam_done = 1'b0;
        chk("pre-reset done", 32'(so_done), 1);
        rst = 1'b0;
        #1;
        chk("midframe rst done", 32'(so_done), 0);
        chk("midframe rst busy", 32'(busy), 0);
        chk("midframe rst data", 32'({so_r, so_g, so_b}), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_q.delete(); outc_q.delete();
        fill_flat(100, 100, 100); drive_frame(0, 0, 0, N); tail(0, bc, bd); check_frame("post_rst_flat", 0, 0);

        fill_rand(255); drive_frame(2, 0, 0, N);
        repeat (2) begin @(negedge clk); cam_done = 1'b0; end
        chk("flush busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        chk("flush rst busy", 32'(busy), 0);
        chk("flush rst done", 32'(so_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        out_q.delete(); outc_q.delete();
        fill_rand(255); drive_frame(2, 0, 1, N); tail(0, bc, bd); check_frame("post_flush_rst_grey", 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
